// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB3 master port among several requesters.
// Single-beat transfers, registered response, watchdog abort on stalled PREADY.
module apb_rr_arbiter #(
  parameter int NB_MASTERS     = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic [NB_MASTERS-1:0]                req_i,
  input  logic [NB_MASTERS-1:0]                we_i,
  input  logic [NB_MASTERS*APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [NB_MASTERS*APB_DATA_WIDTH-1:0] wdata_i,
  output logic [NB_MASTERS-1:0]                done_o,
  output logic [APB_DATA_WIDTH-1:0]            rdata_o,
  output logic                                 err_o,
  output logic                                 timeout_o,
  output logic                                 busy_o,
  output logic [IW-1:0]                        grant_o,
  output logic                                 PSEL,
  output logic                                 PENABLE,
  output logic                                 PWRITE,
  output logic [APB_ADDR_WIDTH-1:0]            PADDR,
  output logic [APB_DATA_WIDTH-1:0]            PWDATA,
  input  logic [APB_DATA_WIDTH-1:0]            PRDATA,
  input  logic                                 PREADY,
  input  logic                                 PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                state_q;
  logic [IW-1:0]             last_q;
  logic [IW-1:0]             idx_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic                      we_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic                      tmo_q;
  logic [CW-1:0]             cnt_q;

  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;
  logic          wd_hit;

  // Scan starts just after the last winner so it gets lowest priority.
  always_comb begin
    win   = last_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NB_MASTERS; k++) begin
      cand = IW'((int'(last_q) + k) % NB_MASTERS);
      if (!found && req_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign wd_hit = WD_EN && (cnt_q == TMAX);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NB_MASTERS - 1);
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            idx_q   <= win;
            last_q  <= win;
            addr_q  <= addr_i[int'(win)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            wdata_q <= wdata_i[int'(win)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            we_q    <= we_i[win];
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q   <= '0;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            rdata_q <= we_q ? '0 : PRDATA;
            err_q   <= PSLVERR;
            tmo_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (wd_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
            state_q <= S_RESP;
          end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_xfer;
  logic resp;

  assign in_xfer   = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign resp      = (state_q == S_RESP);
  assign PSEL      = in_xfer;
  assign PENABLE   = (state_q == S_ACCESS);
  assign PWRITE    = in_xfer ? we_q : 1'b0;
  assign PADDR     = in_xfer ? addr_q : '0;
  assign PWDATA    = in_xfer ? wdata_q : '0;
  assign busy_o    = (state_q != S_IDLE);
  assign grant_o   = idx_q;
  assign rdata_o   = resp ? rdata_q : '0;
  assign err_o     = resp ? err_q : 1'b0;
  assign timeout_o = resp ? tmo_q : 1'b0;

  always_comb begin
    done_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      done_o[i] = resp && (idx_q == IW'(i));
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: one instance with 3 masters and a
// 4-cycle watchdog, one with 2 masters and the watchdog disabled.
module tb_apb_rr_arbiter;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  // Instance B: 2 masters, watchdog off
  logic [1:0]  b_req, b_we, b_done;
  logic [63:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_paddr, b_pwdata, b_prdata;
  logic        b_err, b_tmo, b_busy, b_psel, b_penable, b_pwrite;
  logic        b_pready, b_pslverr;
  logic [0:0]  b_grant;

  // Instance A: 3 masters, 4-cycle watchdog
  logic [2:0]  a_req, a_we, a_done;
  logic [95:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_paddr, a_pwdata, a_prdata;
  logic        a_err, a_tmo, a_busy, a_psel, a_penable, a_pwrite;
  logic        a_pready, a_pslverr;
  logic [1:0]  a_grant;

  apb_rr_arbiter #(
    .NB_MASTERS(2), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(0)
  ) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_i(b_req), .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wdata),
    .done_o(b_done), .rdata_o(b_rdata), .err_o(b_err),
    .timeout_o(b_tmo), .busy_o(b_busy), .grant_o(b_grant),
    .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
    .PADDR(b_paddr), .PWDATA(b_pwdata), .PRDATA(b_prdata),
    .PREADY(b_pready), .PSLVERR(b_pslverr)
  );

  apb_rr_arbiter #(
    .NB_MASTERS(3), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) u_a (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_i(a_req), .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wdata),
    .done_o(a_done), .rdata_o(a_rdata), .err_o(a_err),
    .timeout_o(a_tmo), .busy_o(a_busy), .grant_o(a_grant),
    .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite),
    .PADDR(a_paddr), .PWDATA(a_pwdata), .PRDATA(a_prdata),
    .PREADY(a_pready), .PSLVERR(a_pslverr)
  );

  task automatic test_reset;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    b_prdata = '0; b_pready = 1'b0; b_pslverr = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    a_prdata = '0; a_pready = 1'b0; a_pslverr = 1'b0;
    ARESETn = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({b_psel, b_penable, b_busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_b_ctl: got %b expected 000",
               {b_psel, b_penable, b_busy});
    end
    checks++;
    if (b_done !== 2'b00 || b_grant !== 1'b0) begin
      errors++;
      $display("FAIL rst_b_done_grant: got %b/%b expected 00/0",
               b_done, b_grant);
    end
    checks++;
    if (b_paddr !== 32'h0 || b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_b_data: got %h/%h expected 0/0", b_paddr, b_rdata);
    end
    checks++;
    if ({a_psel, a_busy, a_err, a_tmo} !== 4'b0000 || a_grant !== 2'd0) begin
      errors++;
      $display("FAIL rst_a: got %b grant %0d expected 0000 grant 0",
               {a_psel, a_busy, a_err, a_tmo}, a_grant);
    end
    ARESETn = 1'b1;
  endtask

  task automatic test_zero_wait;
    b_addr[31:0] = 32'h0000_1000;
    b_wdata[31:0] = 32'hDEAD_BEEF;
    b_we[0] = 1'b1;
    b_pready = 1'b1;
    b_req = 2'b01;
    @(negedge ACLK);
    checks++;
    if ({b_psel, b_penable} !== 2'b10) begin
      errors++;
      $display("FAIL zw_setup: got %b expected 10", {b_psel, b_penable});
    end
    checks++;
    if (b_paddr !== 32'h1000 || b_pwdata !== 32'hDEADBEEF || b_pwrite !== 1'b1)
    begin
      errors++;
      $display("FAIL zw_setup_bus: got %h %h %b expected 1000 deadbeef 1",
               b_paddr, b_pwdata, b_pwrite);
    end
    @(negedge ACLK);
    checks++;
    if ({b_psel, b_penable} !== 2'b11) begin
      errors++;
      $display("FAIL zw_access: got %b expected 11", {b_psel, b_penable});
    end
    @(negedge ACLK);
    checks++;
    if (b_done !== 2'b01 || b_err !== 1'b0 || b_psel !== 1'b0) begin
      errors++;
      $display("FAIL zw_wr_done: got done %b err %b psel %b expected 01 0 0",
               b_done, b_err, b_psel);
    end
    b_req = 2'b00;
    @(negedge ACLK);
    b_we[0] = 1'b0;
    b_prdata = 32'hCAFE_F00D;
    b_req = 2'b01;
    repeat (3) @(negedge ACLK);
    checks++;
    if (b_done !== 2'b01 || b_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL zw_rd_done: got done %b rdata %h expected 01 cafef00d",
               b_done, b_rdata);
    end
    b_req = 2'b00;
    @(negedge ACLK);
  endtask

  task automatic test_wait_states;
    b_pready = 1'b0;
    b_addr[63:32] = 32'h0000_2000;
    b_we[1] = 1'b0;
    b_req = 2'b10;
    @(negedge ACLK);
    checks++;
    if ({b_psel, b_penable} !== 2'b10 || b_grant !== 1'b1) begin
      errors++;
      $display("FAIL ws_setup: got %b grant %0d expected 10 grant 1",
               {b_psel, b_penable}, b_grant);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge ACLK);
      checks++;
      if (!(b_psel && b_penable && b_paddr == 32'h2000 && b_done == 2'b00))
      begin
        errors++;
        $display("FAIL ws_stable%0d: got %b%b %h done %b expected 11 2000 00",
                 k, b_psel, b_penable, b_paddr, b_done);
      end
      if (k == 6) b_pready = 1'b1;
    end
    @(negedge ACLK);
    checks++;
    if (b_done !== 2'b10 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL ws_done: got %b err %b expected 10 0", b_done, b_err);
    end
    b_req = 2'b00;
    @(negedge ACLK);
  endtask

  task automatic test_slverr;
    b_pready = 1'b1;
    b_pslverr = 1'b1;
    b_we[0] = 1'b1;
    b_req = 2'b01;
    repeat (3) @(negedge ACLK);
    checks++;
    if (b_done !== 2'b01 || b_err !== 1'b1 || b_tmo !== 1'b0) begin
      errors++;
      $display("FAIL slverr: got done %b err %b tmo %b expected 01 1 0",
               b_done, b_err, b_tmo);
    end
    b_req = 2'b00;
    b_pslverr = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_done;
    logic [31:0] exp_addr;
    logic        found;
    a_pready = 1'b1;
    a_we = 3'b000;
    for (int i = 0; i < 3; i++) a_addr[i*32 +: 32] = 32'hA000_0000 | 32'(i);
    a_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp_done = 3'b001 << (t % 3);
      exp_addr = 32'hA000_0000 | 32'(t % 3);
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge ACLK);
        if (a_psel && !a_penable) found = 1'b1;
      end
      checks++;
      if (!found || a_grant !== 2'(t % 3) || a_paddr !== exp_addr) begin
        errors++;
        $display("FAIL rr_grant%0d: got found %b grant %0d addr %h expected 1 %0d %h",
                 t, found, a_grant, a_paddr, t % 3, exp_addr);
      end
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge ACLK);
        if (a_done != 3'b000) found = 1'b1;
      end
      checks++;
      if (a_done !== exp_done) begin
        errors++;
        $display("FAIL rr_done%0d: got %b expected %b", t, a_done, exp_done);
      end
      a_req[t % 3] = 1'b0;
      @(negedge ACLK);
      if (t < 5) a_req[t % 3] = 1'b1;
    end
    a_req = 3'b000;
    @(negedge ACLK);
  endtask

  task automatic test_watchdog;
    int   cnt;
    logic found;
    a_pready = 1'b0;
    a_prdata = 32'h1234_5678;
    a_we[1] = 1'b0;
    a_addr[63:32] = 32'hB000_0000;
    a_req = 3'b010;
    cnt = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge ACLK);
      if (a_done != 3'b000) found = 1'b1;
      else if (a_psel && a_penable) cnt++;
    end
    checks++;
    if (!found || cnt != 4) begin
      errors++;
      $display("FAIL wd_len: got found %b access %0d expected 1 4", found, cnt);
    end
    checks++;
    if (a_done !== 3'b010 || a_err !== 1'b1 || a_tmo !== 1'b1 ||
        a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wd_resp: got %b err %b tmo %b rdata %h expected 010 1 1 0",
               a_done, a_err, a_tmo, a_rdata);
    end
    a_req = 3'b000;
    @(negedge ACLK);
    a_req = 3'b010;
    cnt = 0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge ACLK);
      if (a_done != 3'b000) found = 1'b1;
      else if (a_psel && a_penable) begin
        cnt++;
        if (cnt == 4) a_pready = 1'b1;
      end
    end
    checks++;
    if (!found || cnt != 4) begin
      errors++;
      $display("FAIL wd_last_len: got found %b access %0d expected 1 4",
               found, cnt);
    end
    checks++;
    if (a_done !== 3'b010 || a_err !== 1'b0 || a_tmo !== 1'b0 ||
        a_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL wd_last_resp: got %b err %b tmo %b rdata %h expected 010 0 0 12345678",
               a_done, a_err, a_tmo, a_rdata);
    end
    a_req = 3'b000;
    a_pready = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_reset_mid;
    int dones;
    b_pready = 1'b0;
    b_we = 2'b00;
    b_addr[31:0] = 32'h0000_1000;
    b_addr[63:32] = 32'h0000_2000;
    b_req = 2'b10;
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if ({b_psel, b_penable, b_busy} !== 3'b000) begin
      errors++;
      $display("FAIL rm_async: got %b expected 000",
               {b_psel, b_penable, b_busy});
    end
    dones = 0;
    repeat (3) begin
      @(negedge ACLK);
      if (b_done != 2'b00) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rm_nodone: got %0d dones expected 0", dones);
    end
    ARESETn = 1'b1;
    b_req = 2'b11;
    b_pready = 1'b1;
    @(negedge ACLK);
    checks++;
    if (b_psel !== 1'b1 || b_grant !== 1'b0 || b_paddr !== 32'h1000) begin
      errors++;
      $display("FAIL rm_prio: got psel %b grant %0d addr %h expected 1 0 1000",
               b_psel, b_grant, b_paddr);
    end
    repeat (2) @(negedge ACLK);
    checks++;
    if (b_done !== 2'b01) begin
      errors++;
      $display("FAIL rm_done0: got %b expected 01", b_done);
    end
    b_req = 2'b10;
    repeat (4) @(negedge ACLK);
    checks++;
    if (b_done !== 2'b10) begin
      errors++;
      $display("FAIL rm_done1: got %b expected 10", b_done);
    end
    b_req = 2'b00;
    @(negedge ACLK);
  endtask

  task automatic test_wd_disabled;
    int dones;
    b_pready = 1'b0;
    b_we[0] = 1'b0;
    b_prdata = 32'h0BAD_F00D;
    b_req = 2'b01;
    dones = 0;
    repeat (1000) begin
      @(negedge ACLK);
      if (b_done != 2'b00) dones++;
    end
    checks++;
    if (dones != 0 || {b_psel, b_penable} !== 2'b11) begin
      errors++;
      $display("FAIL nowd_hold: got dones %0d ctl %b expected 0 11",
               dones, {b_psel, b_penable});
    end
    b_pready = 1'b1;
    @(negedge ACLK);
    checks++;
    if (b_done !== 2'b01 || b_tmo !== 1'b0 || b_rdata !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL nowd_done: got %b tmo %b rdata %h expected 01 0 0badf00d",
               b_done, b_tmo, b_rdata);
    end
    b_req = 2'b00;
    b_pready = 1'b0;
    @(negedge ACLK);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_slverr();
    test_round_robin();
    test_watchdog();
    test_reset_mid();
    test_wd_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter that shares one APB3 master port between `NB_MASTERS` requesters, such as several AXI-to-APB bridges or a debug/config engine. It serialises their single-beat requests into protocol-correct APB SETUP/ACCESS sequences. It returns registered read data and error status to the winning requester, and aborts stalled transfers with a watchdog timeout.

## Interface
- `NB_MASTERS`, default 2: number of requesters, at least 2.
- `APB_ADDR_WIDTH`, default 32: PADDR width.
- `APB_DATA_WIDTH`, default 32: PWDATA/PRDATA width.
- `TIMEOUT_CYCLES`, default 256: ACCESS cycles without PREADY before abort. 0 disables the watchdog.
- `ACLK  in  1`: clock; all logic on its rising edge.
- `ARESETn  in  1`: asynchronous, active-low reset.
- `req_i  in  NB_MASTERS`: per-master request. Held high until that master's `done_o` bit pulses.
- `we_i  in  NB_MASTERS`: per-master write (1) or read (0).
- `addr_i  in  NB_MASTERS*APB_ADDR_WIDTH`: master i occupies `[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]`.
- `wdata_i  in  NB_MASTERS*APB_DATA_WIDTH`: same packing as `addr_i`.
- `done_o  out  NB_MASTERS`: one-cycle completion pulse; one-hot or zero.
- `rdata_o  out  APB_DATA_WIDTH`: read data; valid while any `done_o` bit is high.
- `err_o  out  1`: valid while any `done_o` bit is high. 1 means PSLVERR or timeout.
- `timeout_o  out  1`: valid while any `done_o` bit is high. 1 means the transfer was aborted by the watchdog.
- `busy_o  out  1`: high in SETUP, ACCESS and RESP.
- `grant_o  out  max(1,$clog2(NB_MASTERS))`: index of the current or last granted master.
- `PSEL, PENABLE, PWRITE  out  1`: APB control.
- `PADDR  out  APB_ADDR_WIDTH`, `PWDATA  out  APB_DATA_WIDTH`: APB address and write data.
- `PRDATA  in  APB_DATA_WIDTH`, `PREADY  in  1`, `PSLVERR  in  1`: APB response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - If any `req_i` bit is high, select a winner by scanning from `(last_q+1) mod NB_MASTERS` upward, with wrap-around.
  - Register the winner's index, address, write data and `we` into `idx_q`, `addr_q`, `wdata_q`, `we_q`.
  - Set `last_q <= winner` and go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP:**
  - `PSEL=1`, `PENABLE=0`.
  - `PADDR`, `PWDATA`, `PWRITE` come from the registered copies.
  - Clear the timeout counter and go to ACCESS unconditionally.
- **ACCESS:**
  - `PSEL=1`, `PENABLE=1`, with the same registered address, data and direction.
  - If `PREADY=1`:
    - Capture `rdata_q <= PWRITE ? 0 : PRDATA`, `err_q <= PSLVERR`, `tmo_q <= 0`.
    - Go to RESP.
  - Else if `TIMEOUT_CYCLES!=0` and the counter equals `TIMEOUT_CYCLES-1`:
    - Capture `rdata_q <= 0`, `err_q <= 1`, `tmo_q <= 1`.
    - Go to RESP. PSEL drops in RESP, so the APB slave sees the transfer abandoned.
  - Otherwise increment the counter and stay in ACCESS.
- **RESP:**
  - `done_o[idx_q]=1`.
  - `rdata_o`, `err_o`, `timeout_o` are driven from `rdata_q`, `err_q`, `tmo_q`.
  - `PSEL=0`, `PENABLE=0`. Go to IDLE.
- **Outside RESP:** `done_o=0`, and `rdata_o`, `err_o`, `timeout_o` are 0.
- **Outside SETUP/ACCESS:** `PADDR`, `PWDATA` and `PWRITE` are driven to 0.
- **Requester rule:** `req_i[i]` seen high in IDLE after that master's `done_o` is a new transfer. Changing `we/addr/wdata` while the request is pending has no effect after the grant, because they are registered in IDLE.
- **Fairness:** the last-granted master has lowest priority at the next arbitration. With all masters requesting, grants rotate 0,1,…,N-1,0.
- **Timeout counter:** width `$clog2(TIMEOUT_CYCLES+1)`, minimum 1. It saturates and does not wrap.

## Timing
- **Reset values:**
  - State IDLE; `last_q = NB_MASTERS-1`, so master 0 wins first.
  - `idx_q` and all data/status registers 0.
  - All outputs 0, including `PSEL`, `PENABLE`, `busy_o`, `grant_o`.
- **Reset asserted mid-transfer:** returns to IDLE immediately (asynchronous). No `done_o` is issued for the aborted transfer.
- **Zero-wait slave:** `req_i` high at cycle 0 (IDLE) gives SETUP at 1, ACCESS with PREADY at 2, and `done_o` at cycle 3.
- **Latency:** request-to-done is 3 + W cycles for W PREADY wait states.
- **Throughput:** back-to-back transfers are separated by one IDLE cycle. The next arbitration happens in the IDLE cycle after RESP.
- **Request timing:** requests arriving during SETUP/ACCESS/RESP are only evaluated in IDLE.
- **Timeout with `TIMEOUT_CYCLES=T`:** ACCESS lasts exactly T cycles, then RESP.
- **PREADY on the last ACCESS cycle:** if PREADY arrives on the final cycle (counter = T-1), PREADY wins and there is no timeout.

## Test plan
- **Zero-wait transfers, single master:**
  - Master 0 writes addr 0x1000 / data 0xDEADBEEF with PREADY tied 1 → PSEL at cycle 1, PENABLE at 2, `done_o=2'b01` at 3, `err_o=0`.
  - Then a read of 0x1000 with PRDATA=0xCAFEF00D → `rdata_o=0xCAFEF00D` at done.
- **Round-robin, N=3:**
  - All three masters hold reads, each dropping and re-raising its request after done → grant sequence 0,1,2,0,1,2.
  - Each `done_o` is one-hot, and `PADDR` matches the granted master's address.
- **Wait states:**
  - PREADY low for 5 ACCESS cycles → PSEL/PENABLE and PADDR stable throughout, done at cycle 8.
  - PSLVERR=1 with PREADY → `err_o=1`, `timeout_o=0`.
- **Watchdog, `TIMEOUT_CYCLES=4`:**
  - PREADY never rises → exactly 4 ACCESS cycles, then done with `err_o=1`, `timeout_o=1`, `rdata_o=0`.
  - PREADY on the 4th ACCESS cycle → normal completion with `timeout_o=0`.
- **Reset mid-ACCESS:** `ARESETn` low → PSEL/PENABLE/busy_o drop asynchronously and no done is issued. After release, master 0 has priority over master 1 when both request.
- **Watchdog disabled:** `TIMEOUT_CYCLES=0` with PREADY held low for 1000 cycles → stays in ACCESS with no done. PREADY then high → done on the next cycle.
